// File: rtl/multi_timer_core_if.sv
// Command and status bundle for multi_timer_core: per-channel command pulses in,
// selected-channel display plus per-channel flags out.
interface multi_timer_core_if #(
  parameter int CH_W = 2
);
  localparam int NUM_CH = 2**CH_W;

  logic              timer_mode;
  logic [CH_W-1:0]   ch_sel;
  logic              min_set_p;
  logic              sec_set_p;
  logic              start_stop_p;
  logic              reset_p;
  logic              clear_set_p;
  logic              repeat_p;
  logic [6:0]        disp_min;
  logic [5:0]        disp_sec;
  logic [6:0]        disp_centis;
  logic [6:0]        set_min_val;
  logic [5:0]        set_sec_val;
  logic [NUM_CH-1:0] running;
  logic [NUM_CH-1:0] repeat_en;
  logic [NUM_CH-1:0] done;
  logic [NUM_CH-1:0] done_p;

  modport master (
    output timer_mode, ch_sel, min_set_p, sec_set_p, start_stop_p, reset_p,
           clear_set_p, repeat_p,
    input  disp_min, disp_sec, disp_centis, set_min_val, set_sec_val,
           running, repeat_en, done, done_p
  );

  modport slave (
    input  timer_mode, ch_sel, min_set_p, sec_set_p, start_stop_p, reset_p,
           clear_set_p, repeat_p,
    output disp_min, disp_sec, disp_centis, set_min_val, set_sec_val,
           running, repeat_en, done, done_p
  );
endinterface

// File: rtl/multi_timer_core.sv
// Multi-channel countdown timer (min:sec.centis) with a shared centisecond
// prescaler, per-channel setpoint, run, auto-reload and expiry flags.
module multi_timer_core #(
  parameter int CH_W     = 2,
  parameter int TICK_DIV = 10,
  parameter int MAX_MIN  = 99
) (
  input logic                clk,
  input logic                rst,
  multi_timer_core_if.slave  bus
);
  localparam int NUM_CH = 2**CH_W;
  localparam logic [6:0]  MAX_M    = 7'(MAX_MIN);
  localparam logic [15:0] TICK_TOP = 16'(TICK_DIV - 1);

  typedef struct packed {
    logic [6:0] set_min;
    logic [5:0] set_sec;
    logic [6:0] min;
    logic [5:0] sec;
    logic [6:0] cs;
    logic       run;
    logic       rep;
    logic       done;
    logic       dp;
  } ch_t;

  ch_t         ch_q [NUM_CH];
  ch_t         ch_n [NUM_CH];
  logic [15:0] presc_q, presc_n;
  logic        tick;

  // One centisecond off a running count; expiry either stops or reloads.
  function automatic ch_t step(input ch_t c);
    ch_t r;
    r = c;
    if (c.cs != 7'd0) begin
      r.cs = c.cs - 7'd1;
    end else if (c.sec != 6'd0) begin
      r.sec = c.sec - 6'd1;
      r.cs  = 7'd99;
    end else if (c.min != 7'd0) begin
      r.min = c.min - 7'd1;
      r.sec = 6'd59;
      r.cs  = 7'd99;
    end
    if (r.min == 7'd0 && r.sec == 6'd0 && r.cs == 7'd0) begin
      r.done = 1'b1;
      r.dp   = 1'b1;
      if (r.rep && (r.set_min != 7'd0 || r.set_sec != 6'd0)) begin
        r.min = r.set_min;
        r.sec = r.set_sec;
      end else begin
        r.run = 1'b0;
      end
    end
    return r;
  endfunction

  always_comb begin
    tick    = bus.timer_mode && (presc_q == TICK_TOP);
    presc_n = (!bus.timer_mode || tick) ? 16'd0 : presc_q + 16'd1;
    for (int i = 0; i < NUM_CH; i++) begin
      ch_n[i]    = ch_q[i];
      ch_n[i].dp = 1'b0;
      if (!bus.timer_mode) begin
        ch_n[i] = '0;
      end else if (bus.ch_sel == CH_W'(i)) begin
        if (bus.repeat_p) ch_n[i].rep = ~ch_q[i].rep;
        if (bus.clear_set_p) begin
          ch_n[i] = '0;
        end else if (bus.reset_p) begin
          ch_n[i].min  = ch_q[i].set_min;
          ch_n[i].sec  = ch_q[i].set_sec;
          ch_n[i].cs   = 7'd0;
          ch_n[i].run  = 1'b0;
          ch_n[i].done = 1'b0;
        end else if (bus.start_stop_p) begin
          if (ch_q[i].min != 7'd0 || ch_q[i].sec != 6'd0 || ch_q[i].cs != 7'd0) begin
            ch_n[i].run = ~ch_q[i].run;
            if (!ch_q[i].run) ch_n[i].done = 1'b0;
          end
        end else if (bus.min_set_p || bus.sec_set_p) begin
          // Set pulses while running are dropped but still cost that channel its tick.
          if (!ch_q[i].run) begin
            if (bus.min_set_p)
              ch_n[i].set_min = (ch_q[i].set_min == MAX_M) ? 7'd0 : ch_q[i].set_min + 7'd1;
            else
              ch_n[i].set_sec = (ch_q[i].set_sec == 6'd59) ? 6'd0 : ch_q[i].set_sec + 6'd1;
            ch_n[i].min  = ch_n[i].set_min;
            ch_n[i].sec  = ch_n[i].set_sec;
            ch_n[i].cs   = 7'd0;
            ch_n[i].done = 1'b0;
          end
        end else if (tick && ch_q[i].run) begin
          ch_n[i] = step(ch_n[i]);
        end
      end else if (tick && ch_q[i].run) begin
        ch_n[i] = step(ch_n[i]);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      presc_q         <= '0;
      for (int i = 0; i < NUM_CH; i++) ch_q[i] <= '0;
      bus.disp_min    <= '0;
      bus.disp_sec    <= '0;
      bus.disp_centis <= '0;
      bus.set_min_val <= '0;
      bus.set_sec_val <= '0;
    end else begin
      presc_q         <= presc_n;
      for (int i = 0; i < NUM_CH; i++) ch_q[i] <= ch_n[i];
      bus.disp_min    <= ch_n[bus.ch_sel].min;
      bus.disp_sec    <= ch_n[bus.ch_sel].sec;
      bus.disp_centis <= ch_n[bus.ch_sel].cs;
      bus.set_min_val <= ch_n[bus.ch_sel].set_min;
      bus.set_sec_val <= ch_n[bus.ch_sel].set_sec;
    end
  end

  always_comb begin
    bus.running   = '0;
    bus.repeat_en = '0;
    bus.done      = '0;
    bus.done_p    = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      bus.running[i]   = ch_q[i].run;
      bus.repeat_en[i] = ch_q[i].rep;
      bus.done[i]      = ch_q[i].done;
      bus.done_p[i]    = ch_q[i].dp;
    end
  end
endmodule
